// File: rtl/ccff_frame_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_frame_loader_if
//   Valid/ready word channel feeding the configuration-frame loader.
//
//   cfg_word  : configuration word, driven by the producer
//   cfg_valid : cfg_word is valid, driven by the producer
//   cfg_ready : loader accepts a word this cycle, driven by the loader
//
//   master : producer side (testbench or upstream controller)
//   slave  : loader side
// ---------------------------------------------------------------------------
interface ccff_frame_loader_if #(
    parameter int WORD_W = 8
) ();
    logic [WORD_W-1:0] cfg_word;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (
        output cfg_word,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_word,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/ccff_frame_loader.sv
// ---------------------------------------------------------------------------
// ccff_frame_loader
//   Accepts NUM_WORDS configuration words over a valid/ready channel,
//   serialises each one (bit 0 first) into a NUM_BITS configuration chain,
//   then commits the whole chain into a shadow register in one cycle. The
//   shadow register drives the TGATE sel/selb pairs, so the routing muxes
//   never see the chain while it is shifting.
//
//   Parameters
//     NUM_BITS : chain length, must be a multiple of WORD_W
//     WORD_W   : configuration word width
//
//   Ports
//     prog_clk  : programming clock, rising edge
//     pReset    : synchronous active-high reset
//     cfg_start : start a frame, only looked at while idle
//     cfg_if    : word channel (cfg_word / cfg_valid / cfg_ready)
//     busy      : high in every state except IDLE
//     cfg_done  : one-cycle pulse when the committed frame is visible
//     ccff_tail : last chain bit, for daisy-chaining the next loader
//     mem_out   : committed configuration (TGATE sel)
//     mem_outb  : bitwise inverse of mem_out (TGATE selb)
// ---------------------------------------------------------------------------
module ccff_frame_loader #(
    parameter int NUM_BITS = 16,
    parameter int WORD_W   = 8
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                cfg_start,
    ccff_frame_loader_if.slave  cfg_if,
    output logic                busy,
    output logic                cfg_done,
    output logic                ccff_tail,
    output logic [NUM_BITS-1:0] mem_out,
    output logic [NUM_BITS-1:0] mem_outb
);

    localparam int NUM_WORDS = NUM_BITS / WORD_W;
    localparam int BIT_CW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WORD_CW   = $clog2(NUM_WORDS + 1);

    localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(WORD_W - 1);
    localparam logic [WORD_CW-1:0] WORD_LAST = WORD_CW'(NUM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    state_t              state_q,    state_d;
    logic [NUM_BITS-1:0] shreg_q,    shreg_d;
    logic [WORD_W-1:0]   word_reg_q, word_reg_d;
    logic [BIT_CW-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [WORD_CW-1:0]  word_cnt_q, word_cnt_d;
    logic [NUM_BITS-1:0] mem_q,      mem_d;
    logic                done_q,     done_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            word_reg_q <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            mem_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            word_reg_q <= word_reg_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            mem_q      <= mem_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        word_reg_d = word_reg_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        mem_d      = mem_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (cfg_if.cfg_valid) begin
                    word_reg_d = cfg_if.cfg_word;
                    word_cnt_d = word_cnt_q + WORD_CW'(1);
                    state_d    = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // Left shift: the first bit in travels towards the tail, so
                // word 0 bit 0 finishes at shreg[NUM_BITS-1].
                shreg_d    = (shreg_q << 1) | NUM_BITS'(word_reg_q[0]);
                word_reg_d = word_reg_q >> 1;
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    // word_cnt already counts the word being shifted out.
                    state_d   = (word_cnt_q == WORD_LAST) ? ST_COMMIT : ST_LOAD;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CW'(1);
                end
            end

            ST_COMMIT: begin
                mem_d      = shreg_q;
                done_d     = 1'b1;
                word_cnt_d = '0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cfg_if.cfg_ready = (state_q == ST_LOAD);
    assign busy             = (state_q != ST_IDLE);
    assign cfg_done         = done_q;
    assign ccff_tail        = shreg_q[NUM_BITS-1];
    assign mem_out          = mem_q;
    // Derived from the shadow register, so selb is all ones out of reset
    // and can only move together with sel.
    assign mem_outb         = ~mem_q;

endmodule

// File: tb/tb_ccff_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_frame_loader
//   Directed bench for ccff_frame_loader (NUM_BITS=16, WORD_W=8).
//   Word k bit j lands at mem_out[15-(8k+j)], i.e. each word appears
//   bit-reversed, word 0 in the upper byte.
// ---------------------------------------------------------------------------
module tb_ccff_frame_loader;

    logic        prog_clk;
    logic        pReset;
    logic        cfg_start;
    logic        busy;
    logic        cfg_done;
    logic        ccff_tail;
    logic [15:0] mem_out;
    logic [15:0] mem_outb;

    int total;
    int bad;

    ccff_frame_loader_if #(.WORD_W(8)) cfg_if ();

    ccff_frame_loader #(
        .NUM_BITS (16),
        .WORD_W   (8)
    ) dut (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .cfg_start (cfg_start),
        .cfg_if    (cfg_if.slave),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .ccff_tail (ccff_tail),
        .mem_out   (mem_out),
        .mem_outb  (mem_outb)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Runs one frame from the cfg_start edge (edge 0). Returns the edge index
    // at which cfg_done was first seen and the first edge showing ccff_tail=1.
    task automatic run_frame(input logic [7:0] w0, input logic [7:0] w1,
                             input int stall, input bit poke_start,
                             input logic [15:0] prev_mem,
                             output int done_at, output int tail_at);
        int  widx;
        int  stall_left;
        int  unstable;
        int  stall_bad;
        bit  accept;
        bit  stalled;
        widx       = 0;
        stall_left = stall;
        unstable   = 0;
        stall_bad  = 0;
        done_at    = -1;
        tail_at    = -1;

        cfg_start        = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_word  = w0;
        tick();
        cfg_start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);

        for (int n = 1; n <= 200 && done_at < 0; n++) begin
            cfg_start = poke_start && (n == 5);
            stalled   = 1'b0;
            if (cfg_if.cfg_ready && widx == 1 && stall_left > 0) begin
                cfg_if.cfg_valid = 1'b0;
                stall_left--;
                stalled = 1'b1;
            end else begin
                cfg_if.cfg_valid = 1'b1;
            end
            accept = cfg_if.cfg_ready && cfg_if.cfg_valid;
            tick();
            if (accept) begin
                widx++;
                cfg_if.cfg_word = w1;
            end
            if (stalled && !cfg_if.cfg_ready) stall_bad++;
            if (cfg_done) done_at = n;
            else if (mem_out !== prev_mem || mem_outb !== ~prev_mem) unstable++;
            if (tail_at < 0 && ccff_tail) tail_at = n;
        end
        cfg_start        = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        check("mem_stable", 32'(unstable), 32'd0);
        check("busy_fall", 32'(busy), 32'd0);
        if (stall > 0) check("stall_ready", 32'(stall_bad), 32'd0);
    endtask

    // After a frame: no further done pulse and no new frame starting.
    task automatic quiet_check(input string tag);
        int extra;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cfg_done || busy) extra++;
        end
        check(tag, 32'(extra), 32'd0);
    endtask

    initial begin
        int done_at;
        int tail_at;
        total            = 0;
        bad              = 0;
        pReset           = 1'b1;
        cfg_start        = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_word  = '0;

        // Reset values
        tick();
        tick();
        check("rst_mem",   32'(mem_out),   32'h0000);
        check("rst_memb",  32'(mem_outb),  32'hFFFF);
        check("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(cfg_done),  32'd0);
        check("rst_tail",  32'(ccff_tail), 32'd0);
        pReset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Back-to-back load, then restart in the cfg_done cycle
        run_frame(8'hA5, 8'h3C, 0, 1'b0, 16'h0000, done_at, tail_at);
        check("f1_latency", 32'(done_at), 32'd19);
        check("f1_mem",  32'(mem_out),  32'hA53C);
        check("f1_memb", 32'(mem_outb), 32'h5AC3);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("restart_busy",  32'(busy), 32'd1);
        check("restart_ready", 32'(cfg_if.cfg_ready), 32'd1);
        check("restart_hold",  32'(mem_out), 32'hA53C);
        pReset = 1'b1;
        tick();
        pReset = 1'b0;
        check("rst_clears_mem", 32'(mem_out), 32'h0000);
        check("rst_from_load",  32'(busy),    32'd0);

        // Stalled second word: 5 extra edges
        run_frame(8'h12, 8'h34, 5, 1'b0, 16'h0000, done_at, tail_at);
        check("f2_latency", 32'(done_at), 32'd24);
        check("f2_mem",  32'(mem_out),  32'h482C);
        check("f2_memb", 32'(mem_outb), 32'hB7D3);
        quiet_check("f2_quiet");

        // cfg_start pulsed during SHIFT is ignored
        run_frame(8'h0F, 8'hF0, 0, 1'b1, 16'h482C, done_at, tail_at);
        check("f3_latency", 32'(done_at), 32'd19);
        check("f3_mem", 32'(mem_out), 32'hF00F);
        quiet_check("f3_no_extra_frame");

        // Reset on the 4th shift of word 1 (edge 14)
        cfg_start        = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_word  = 8'hAA;
        tick();
        cfg_start = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            tick();
            if (n == 1) cfg_if.cfg_word = 8'h55;
        end
        check("pre_rst_busy", 32'(busy),    32'd1);
        check("pre_rst_mem",  32'(mem_out), 32'hF00F);
        pReset = 1'b1;
        tick();
        pReset           = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
        check("mid_rst_done",  32'(cfg_done),  32'd0);
        check("mid_rst_tail",  32'(ccff_tail), 32'd0);
        check("mid_rst_mem",   32'(mem_out),   32'h0000);
        check("mid_rst_memb",  32'(mem_outb),  32'hFFFF);

        run_frame(8'hFF, 8'hFF, 0, 1'b0, 16'h0000, done_at, tail_at);
        check("f4_latency", 32'(done_at), 32'd19);
        check("f4_mem",  32'(mem_out),  32'hFFFF);
        check("f4_memb", 32'(mem_outb), 32'h0000);

        // Daisy chain: word 0 bit 0 reaches the tail on the 16th shift (edge 18)
        pReset = 1'b1;
        tick();
        pReset = 1'b0;
        check("dc_tail_clear", 32'(ccff_tail), 32'd0);
        run_frame(8'h01, 8'h00, 0, 1'b0, 16'h0000, done_at, tail_at);
        check("dc_tail_edge", 32'(tail_at), 32'd18);
        check("dc_tail_hold", 32'(ccff_tail), 32'd1);
        check("dc_mem", 32'(mem_out), 32'h8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
